// File: rtl/pe_pkg.sv
// Shared types and default sizes for the nucleotide-selection PE and its job sequencer.
package pe_pkg;

    localparam int unsigned NUCL_PER_WORD = 16;
    localparam int unsigned ROW_W         = 40;
    localparam int unsigned LEN_W         = 16;
    localparam int unsigned NUM_MAT       = 4;

    typedef enum logic [1:0] {
        NUC_A = 2'b00,
        NUC_C = 2'b01,
        NUC_G = 2'b10,
        NUC_T = 2'b11
    } nucl_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/pe_mat_table.sv
// Per-branch probability matrix table: reset-to-zero register file,
// one synchronous write port and one asynchronous read port.
module pe_mat_table #(
    parameter int unsigned ROW_W   = pe_pkg::ROW_W,
    parameter int unsigned NUM_MAT = pe_pkg::NUM_MAT,
    localparam int unsigned MAT_AW = $clog2(NUM_MAT),
    localparam int unsigned MAT_W  = 4 * ROW_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [MAT_AW-1:0] waddr,
    input  logic [MAT_W-1:0]  wdata,
    input  logic [MAT_AW-1:0] raddr,
    output logic [MAT_W-1:0]  rdata
);

    logic [MAT_W-1:0] mem [NUM_MAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_MAT; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Combinational read returns the pre-write contents during a same-cycle write.
    assign rdata = mem[raddr];

endmodule

// File: rtl/pe_job_sequencer.sv
// Sequences one alignment job through the 1-cycle nucleotide-selection PE:
// latches the job matrix, issues nucleotide words and tracks PE output validity.
module pe_job_sequencer #(
    parameter int unsigned NUCL_PER_WORD = pe_pkg::NUCL_PER_WORD,
    parameter int unsigned ROW_W         = pe_pkg::ROW_W,
    parameter int unsigned LEN_W         = pe_pkg::LEN_W,
    parameter int unsigned NUM_MAT       = pe_pkg::NUM_MAT,
    localparam int unsigned MAT_AW       = $clog2(NUM_MAT),
    localparam int unsigned MAT_W        = 4 * ROW_W,
    localparam int unsigned WORD_W       = 2 * NUCL_PER_WORD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  job_len,
    input  logic [MAT_AW-1:0] job_mat_sel,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    input  logic              mat_we,
    input  logic [MAT_AW-1:0] mat_addr,
    input  logic [MAT_W-1:0]  mat_wdata,
    output logic              mat_err,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_nucl,
    output logic [WORD_W-1:0] pe_nucl,
    output logic [MAT_W-1:0]  pe_matrix,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [LEN_W-1:0]  out_idx
);

    import pe_pkg::state_t;
    import pe_pkg::IDLE;
    import pe_pkg::RUN;
    import pe_pkg::DRAIN;
    import pe_pkg::DONE;

    state_t            state;
    logic              s1;
    logic              s2;
    logic [LEN_W-1:0]  len_r;
    logic [LEN_W-1:0]  issue_cnt;
    logic [LEN_W-1:0]  word_idx;
    logic [MAT_AW-1:0] act_sel;
    logic [MAT_W-1:0]  tbl_rdata;
    logic              tbl_we;
    logic              mat_conflict;
    logic              issue;
    logic              consume;
    logic              last_consumed;

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign out_valid = s2;
    assign out_last  = s2 && (out_idx == len_r - LEN_W'(1));

    // A new word may only enter once the PE result it would overwrite has been taken.
    assign in_ready      = (state == RUN) && !s1 && (!s2 || out_ready);
    assign issue         = in_valid && in_ready;
    assign consume       = s2 && out_ready;
    assign last_consumed = consume && out_last;

    assign mat_conflict = mat_we && busy && (mat_addr == act_sel);
    assign tbl_we       = mat_we && !mat_conflict;

    pe_mat_table #(
        .ROW_W   (ROW_W),
        .NUM_MAT (NUM_MAT)
    ) u_table (
        .clk   (clk),
        .rst   (reset),
        .we    (tbl_we),
        .waddr (mat_addr),
        .wdata (mat_wdata),
        .raddr (job_mat_sel),
        .rdata (tbl_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            s1        <= 1'b0;
            s2        <= 1'b0;
            len_r     <= '0;
            issue_cnt <= '0;
            word_idx  <= '0;
            act_sel   <= '0;
            out_idx   <= '0;
            pe_nucl   <= '0;
            pe_matrix <= '0;
            mat_err   <= 1'b0;
        end else begin
            if (mat_conflict) begin
                mat_err <= 1'b1;
            end
            if (abort) begin
                state     <= IDLE;
                s1        <= 1'b0;
                s2        <= 1'b0;
                issue_cnt <= '0;
                word_idx  <= '0;
                out_idx   <= '0;
            end else begin
                // The PE captures pe_nucl on every edge; s1 marks that capture.
                if (s1) begin
                    s1      <= 1'b0;
                    s2      <= 1'b1;
                    out_idx <= word_idx;
                end else if (consume) begin
                    s2 <= 1'b0;
                end

                case (state)
                    IDLE: begin
                        if (start) begin
                            pe_matrix <= tbl_rdata;
                            act_sel   <= job_mat_sel;
                            len_r     <= job_len;
                            issue_cnt <= '0;
                            word_idx  <= '0;
                            out_idx   <= '0;
                            mat_err   <= 1'b0;
                            state     <= (job_len == '0) ? DONE : RUN;
                        end
                    end
                    RUN: begin
                        if (issue) begin
                            pe_nucl   <= in_nucl;
                            word_idx  <= issue_cnt;
                            issue_cnt <= issue_cnt + LEN_W'(1);
                            s1        <= 1'b1;
                            if (issue_cnt == len_r - LEN_W'(1)) begin
                                state <= DRAIN;
                            end
                        end
                    end
                    DRAIN: begin
                        if (last_consumed) begin
                            state <= DONE;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pe_job_sequencer.sv
// Scoreboard bench for pe_job_sequencer with a behavioural stand-in for the PE.
module tb_pe_job_sequencer;
    import pe_pkg::*;

    localparam int unsigned NPW = NUCL_PER_WORD;
    localparam int unsigned RW  = ROW_W;
    localparam int unsigned LW  = LEN_W;
    localparam int unsigned NM  = NUM_MAT;
    localparam int unsigned AW  = $clog2(NM);
    localparam int unsigned MW  = 4 * RW;
    localparam int unsigned WW  = 2 * NPW;

    logic          clk;
    logic          reset;
    logic          start;
    logic [LW-1:0] job_len;
    logic [AW-1:0] job_mat_sel;
    logic          abort;
    logic          busy;
    logic          done;
    logic          mat_we;
    logic [AW-1:0] mat_addr;
    logic [MW-1:0] mat_wdata;
    logic          mat_err;
    logic          in_valid;
    logic          in_ready;
    logic [WW-1:0] in_nucl;
    logic [WW-1:0] pe_nucl;
    logic [MW-1:0] pe_matrix;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic [LW-1:0] out_idx;

    pe_job_sequencer #(
        .NUCL_PER_WORD (NPW),
        .ROW_W         (RW),
        .LEN_W         (LW),
        .NUM_MAT       (NM)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .job_len     (job_len),
        .job_mat_sel (job_mat_sel),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .mat_we      (mat_we),
        .mat_addr    (mat_addr),
        .mat_wdata   (mat_wdata),
        .mat_err     (mat_err),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_nucl     (in_nucl),
        .pe_nucl     (pe_nucl),
        .pe_matrix   (pe_matrix),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .out_idx     (out_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PE stand-in: each lane selects the matrix row named by its nucleotide, one cycle later.
    logic [RW-1:0] pe_sel [NPW];
    always @(posedge clk) begin
        for (int k = 0; k < NPW; k++) begin
            case (pe_nucl[2*k +: 2])
                2'b00:   pe_sel[k] <= pe_matrix[4*RW-1 -: RW];
                2'b01:   pe_sel[k] <= pe_matrix[3*RW-1 -: RW];
                2'b10:   pe_sel[k] <= pe_matrix[2*RW-1 -: RW];
                default: pe_sel[k] <= pe_matrix[RW-1:0];
            endcase
        end
    end

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [LW-1:0] idx;
        logic [WW-1:0] word;
        logic [MW-1:0] mat;
        logic          last;
    } exp_t;

    exp_t          sbq[$];
    int unsigned   hs_cyc[$];
    logic [MW-1:0] model_tbl [NM];
    logic [MW-1:0] job_mat;
    int unsigned   job_len_m;
    int unsigned   job_sent;
    logic [AW-1:0] cur_sel;
    bit            in_job;
    bit            ready_rand;
    logic          ready_val;

    task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [RW-1:0] pick(input logic [MW-1:0] m, input logic [1:0] n);
        logic [MW-1:0] t;
        t = m >> (RW * (3 - int'(n)));
        return t[RW-1:0];
    endfunction

    function automatic logic [MW-1:0] rnd_mat();
        return {$urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    always @(posedge clk) begin
        #2;
        out_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_val;
    end

    // Monitor: pops one expectation per output handshake; also checks hold under backpressure.
    exp_t          mon_e;
    bit            prev_stall = 0;
    logic [LW-1:0] prev_idx;
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", MW'(out_valid), MW'(1));
                chk("hold_idx", MW'(out_idx), MW'(prev_idx));
            end
            if (!out_valid) chk("last_without_valid", MW'(out_last), MW'(0));
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output actual idx=%0d required none", out_idx);
                end else begin
                    int bad;
                    mon_e = sbq.pop_front();
                    chk("out_idx", MW'(out_idx), MW'(mon_e.idx));
                    chk("out_last", MW'(out_last), MW'(mon_e.last));
                    chk("pe_nucl", MW'(pe_nucl), MW'(mon_e.word));
                    chk("pe_matrix", pe_matrix, mon_e.mat);
                    bad = -1;
                    for (int k = 0; k < NPW; k++) begin
                        if (bad < 0 && pe_sel[k] !== pick(mon_e.mat, mon_e.word[2*k +: 2])) bad = k;
                    end
                    checks++;
                    if (bad >= 0) begin
                        errors++;
                        $display("FAIL pe_data lane %0d actual=%0h required=%0h", bad, pe_sel[bad],
                                 pick(mon_e.mat, mon_e.word[2*bad +: 2]));
                    end
                    hs_cyc.push_back(cyc);
                end
            end
            prev_stall = out_valid && !out_ready && !abort;
            prev_idx   = out_idx;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_mat(input logic [AW-1:0] a, input logic [MW-1:0] d);
        mat_we = 1'b1;
        mat_addr = a;
        mat_wdata = d;
        tick();
        mat_we = 1'b0;
        if (!(in_job && a == cur_sel)) model_tbl[a] = d;
    endtask

    task automatic start_job(input int unsigned len, input logic [AW-1:0] sel,
                             input bit wr_same, input logic [MW-1:0] d);
        start = 1'b1;
        job_len = LW'(len);
        job_mat_sel = sel;
        if (wr_same) begin
            mat_we = 1'b1;
            mat_addr = sel;
            mat_wdata = d;
        end
        tick();
        start = 1'b0;
        mat_we = 1'b0;
        job_mat = model_tbl[sel];
        if (wr_same) model_tbl[sel] = d;
        job_len_m = len;
        job_sent = 0;
        cur_sel = sel;
        in_job = 1;
        chk("start_busy", MW'(busy), MW'(1));
        chk("start_mat_err", MW'(mat_err), MW'(0));
        chk("start_matrix", pe_matrix, job_mat);
    endtask

    task automatic feed(input logic [WW-1:0] w);
        bit   got;
        exp_t e;
        got = 0;
        in_valid = 1'b1;
        in_nucl = w;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1;
                e.idx  = LW'(job_sent);
                e.word = w;
                e.mat  = job_mat;
                e.last = (job_sent == job_len_m - 1);
                sbq.push_back(e);
                job_sent++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL feed_timeout actual=no in_ready required=accept");
        end
    endtask

    task automatic wait_done(input string tag);
        bit got;
        got = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            if (done) got = 1;
            else tick();
        end
        chk({tag, "_done_seen"}, MW'(got), MW'(1));
        tick();
        chk({tag, "_done_pulse"}, MW'(done), MW'(0));
        chk({tag, "_idle"}, MW'(busy), MW'(0));
        chk({tag, "_drained"}, MW'(sbq.size()), MW'(0));
        in_job = 0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, MW'(busy), MW'(0));
        chk({tag, "_done"}, MW'(done), MW'(0));
        chk({tag, "_in_ready"}, MW'(in_ready), MW'(0));
        chk({tag, "_out_valid"}, MW'(out_valid), MW'(0));
        chk({tag, "_out_last"}, MW'(out_last), MW'(0));
        chk({tag, "_out_idx"}, MW'(out_idx), MW'(0));
        chk({tag, "_pe_nucl"}, MW'(pe_nucl), MW'(0));
        chk({tag, "_pe_matrix"}, pe_matrix, MW'(0));
        chk({tag, "_mat_err"}, MW'(mat_err), MW'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    logic [MW-1:0] m2;
    logic [MW-1:0] mx;
    logic [MW-1:0] my;
    int unsigned   rlen;
    logic [AW-1:0] rsel;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        job_len = '0;
        job_mat_sel = '0;
        abort = 1'b0;
        mat_we = 1'b0;
        mat_addr = '0;
        mat_wdata = '0;
        in_valid = 1'b0;
        in_nucl = '0;
        ready_rand = 0;
        ready_val = 1'b1;
        in_job = 0;
        cur_sel = '0;
        for (int i = 0; i < NM; i++) model_tbl[i] = '0;
        repeat (3) tick();
        check_zero("rst");
        reset = 1'b0;
        tick();

        // Reset in the middle of a job
        write_mat(AW'(1), rnd_mat());
        start_job(3, AW'(1), 0, '0);
        feed(32'h1234_5678);
        #3;
        reset = 1'b1;
        #1;
        check_zero("midrst");
        sbq.delete();
        in_job = 0;
        for (int i = 0; i < NM; i++) model_tbl[i] = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_busy", MW'(busy), MW'(0));
        chk("post_rst_in_ready", MW'(in_ready), MW'(0));

        // Directed three-word job with the reference matrix
        m2 = {40'hAAAAAAAAAA, 40'hCCCCCCCCCC, 40'h6666666666, 40'h3333333333};
        write_mat(AW'(2), m2);
        hs_cyc.delete();
        start_job(3, AW'(2), 0, '0);
        feed(32'h0000_0000);
        feed(32'hFFFF_FFFF);
        feed(32'h1B1B_1B1B);
        wait_done("job3");
        chk("hs_count", MW'(hs_cyc.size()), MW'(3));
        if (hs_cyc.size() == 3) begin
            chk("hs_gap01", MW'(hs_cyc[1] - hs_cyc[0]), MW'(2));
            chk("hs_gap12", MW'(hs_cyc[2] - hs_cyc[1]), MW'(2));
        end

        // Backpressure at idx 1
        start_job(3, AW'(2), 0, '0);
        feed(32'h5555_AAAA);
        feed(32'hC3C3_3C3C);
        ready_val = 1'b0;
        in_valid = 1'b1;
        in_nucl = 32'h0F0F_F0F0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", MW'(in_ready), MW'(0));
            chk("bp_out_valid", MW'(out_valid), MW'(1));
            chk("bp_out_idx", MW'(out_idx), MW'(1));
            chk("bp_pe_nucl", MW'(pe_nucl), MW'(32'hC3C3_3C3C));
            tick();
        end
        in_valid = 1'b0;
        ready_val = 1'b1;
        feed(32'h0F0F_F0F0);
        wait_done("bp");

        // Zero-length job
        start_job(0, AW'(0), 0, '0);
        chk("len0_done", MW'(done), MW'(1));
        chk("len0_in_ready", MW'(in_ready), MW'(0));
        chk("len0_out_valid", MW'(out_valid), MW'(0));
        wait_done("len0");

        // Table writes while busy
        write_mat(AW'(1), rnd_mat());
        start_job(2, AW'(1), 0, '0);
        feed($urandom);
        mx = rnd_mat();
        write_mat(AW'(3), mx);
        chk("wr_other_err", MW'(mat_err), MW'(0));
        my = rnd_mat();
        write_mat(AW'(1), my);
        chk("wr_active_err", MW'(mat_err), MW'(1));
        chk("wr_active_matrix", pe_matrix, job_mat);
        feed($urandom);
        wait_done("werr");
        chk("err_sticky", MW'(mat_err), MW'(1));
        start_job(1, AW'(3), 1, rnd_mat());
        feed($urandom);
        wait_done("rbw");
        start_job(2, AW'(1), 0, '0);
        feed($urandom);
        feed($urandom);
        wait_done("drop");

        // Abort with a word in flight to the PE
        start_job(4, AW'(0), 0, '0);
        feed(32'hDEAD_BEEF);
        abort = 1'b1;
        sbq.delete();
        tick();
        abort = 1'b0;
        in_job = 0;
        chk("abort_busy", MW'(busy), MW'(0));
        chk("abort_matrix", pe_matrix, job_mat);
        chk("abort_nucl", MW'(pe_nucl), MW'(32'hDEAD_BEEF));
        for (int i = 0; i < 4; i++) begin
            chk("abort_no_valid", MW'(out_valid), MW'(0));
            chk("abort_no_done", MW'(done), MW'(0));
            tick();
        end
        start_job(3, AW'(2), 0, '0);
        for (int i = 0; i < 3; i++) feed($urandom);
        wait_done("after_abort");

        // Randomised jobs with random stalls on both sides
        ready_rand = 1;
        for (int j = 0; j < 12; j++) begin
            rlen = $urandom_range(1, 6);
            rsel = AW'($urandom_range(0, NM - 1));
            if ($urandom_range(0, 1) == 1) write_mat(AW'($urandom_range(0, NM - 1)), rnd_mat());
            start_job(rlen, rsel, 0, '0);
            for (int i = 0; i < int'(rlen); i++) begin
                repeat ($urandom_range(0, 2)) tick();
                if (i == 1) write_mat(AW'($urandom_range(0, NM - 1)), rnd_mat());
                feed($urandom);
            end
            wait_done("rnd");
        end
        ready_rand = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
